field_merge_engine: RTL and testbench

Sequential, parametrised engine that overlays, checks or erases a BLK_N×BLK_N tetromino matrix on a FIELD_W×FIELD_H playfield bitmap. It replaces the combinational field merge in the Tetris datapath. It runs between the game-control FSM, which supplies the block position, matrix and background, and the display/collision logic, which consumes `field_display`, `collision` and `hit_count` after `done`. It scans one block cell per clock, so the field width and height can scale without a wide combinational cone.

---
 rtl/field_merge_engine.sv | 150 +++++++++++++++
 tb/tb_field_merge_engine.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/field_merge_engine.sv
// Sequential field merge: scans a BLK_N x BLK_N block matrix one cell per clock and
// overlays, checks or erases it on a FIELD_W x FIELD_H playfield bitmap.
module field_merge_engine #(
  parameter int unsigned FIELD_W = 20,
  parameter int unsigned FIELD_H = 20,
  parameter int unsigned BLK_N   = 4,
  parameter int unsigned POS_W   = 5,
  localparam int unsigned HC_W   = $clog2(BLK_N * BLK_N + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_start,
  input  logic [1:0]                 i_mode,
  input  logic [POS_W-1:0]           i_block_pos_x,
  input  logic [POS_W-1:0]           i_block_pos_y,
  input  logic [BLK_N*BLK_N-1:0]     i_block_matrix,
  input  logic [FIELD_W*FIELD_H-1:0] i_field_background,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_collision,
  output logic [HC_W-1:0]            o_hit_count,
  output logic [FIELD_W*FIELD_H-1:0] o_field_display
);

  localparam int unsigned NCELL = BLK_N * BLK_N;
  localparam int unsigned NBITS = FIELD_W * FIELD_H;
  localparam int unsigned BXW   = (BLK_N > 1) ? $clog2(BLK_N) : 1;
  localparam int unsigned CIW   = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam int unsigned FIW   = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int unsigned AW    = POS_W + 1;

  localparam logic [1:0] ModeMerge = 2'd1;
  localparam logic [1:0] ModeClear = 2'd2;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } state_e;

  state_e                r_state;
  logic [1:0]            r_mode;
  logic [POS_W-1:0]      r_pos_x;
  logic [POS_W-1:0]      r_pos_y;
  logic [NCELL-1:0]      r_matrix;
  logic [BXW-1:0]        r_bx;
  logic [BXW-1:0]        r_by;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_collision;
  logic [HC_W-1:0]       r_hit_count;
  logic [NBITS-1:0]      r_field;

  logic [AW-1:0]         w_fx;
  logic [AW-1:0]         w_fy;
  logic [FIW-1:0]        w_idx;
  logic [CIW-1:0]        w_cell;
  logic                  w_oob;
  logic                  w_occ;
  logic                  w_cur;
  logic                  w_hit;
  logic                  w_wr_en;
  logic                  w_last_col;
  logic                  w_last;

  // Address is widened by one bit so a position near the edge plus b_x cannot wrap.
  always_comb begin
    w_fx       = AW'(r_pos_x) + AW'(r_bx);
    w_fy       = AW'(r_pos_y) + AW'(r_by);
    w_oob      = (32'(w_fx) >= FIELD_W) || (32'(w_fy) >= FIELD_H);
    w_idx      = FIW'(32'(w_fy) * FIELD_W + 32'(w_fx));
    w_cell     = CIW'(32'(r_by) * BLK_N + 32'(r_bx));
    w_occ      = r_matrix[w_cell];
    w_cur      = w_oob ? 1'b0 : r_field[w_idx];
    // CLEAR flags erasing an absent cell; CHECK/MERGE flag an occupied one.
    w_hit      = w_occ & (w_oob | ((r_mode == ModeClear) ? ~w_cur : w_cur));
    w_wr_en    = w_occ & ~w_oob & ((r_mode == ModeMerge) | (r_mode == ModeClear));
    w_last_col = (r_bx == BXW'(BLK_N - 1));
    w_last     = w_last_col && (r_by == BXW'(BLK_N - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_mode      <= 2'd0;
      r_pos_x     <= '0;
      r_pos_y     <= '0;
      r_matrix    <= '0;
      r_bx        <= '0;
      r_by        <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_collision <= 1'b0;
      r_hit_count <= '0;
      r_field     <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_mode      <= i_mode;
            r_pos_x     <= i_block_pos_x;
            r_pos_y     <= i_block_pos_y;
            r_matrix    <= i_block_matrix;
            r_field     <= i_field_background;
            r_collision <= 1'b0;
            r_hit_count <= '0;
            r_bx        <= '0;
            r_by        <= '0;
            r_busy      <= 1'b1;
            r_state     <= StScan;
          end
        end
        StScan: begin
          if (w_hit) begin
            r_collision <= 1'b1;
            r_hit_count <= r_hit_count + HC_W'(1);
          end
          if (w_wr_en) begin
            r_field[w_idx] <= (r_mode == ModeMerge);
          end
          if (w_last_col) begin
            r_bx <= '0;
            r_by <= r_by + 1'b1;
          end else begin
            r_bx <= r_bx + 1'b1;
          end
          if (w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StDone;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_collision     = r_collision;
  assign o_hit_count     = r_hit_count;
  assign o_field_display = r_field;

endmodule

// File: tb/tb_field_merge_engine.sv
// Scoreboard bench for field_merge_engine: directed operations push expected results,
// a negedge monitor pops and compares whenever done is presented.
module tb_field_merge_engine;

  localparam int unsigned NB  = 400;
  localparam int unsigned HCW = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [1:0]      mode = 2'd0;
  logic [4:0]      px = '0;
  logic [4:0]      py = '0;
  logic [15:0]     mat = '0;
  logic [NB-1:0]   bg = '0;
  logic            o_busy;
  logic            o_done;
  logic            o_collision;
  logic [HCW-1:0]  o_hit_count;
  logic [NB-1:0]   o_field_display;

  field_merge_engine #(
    .FIELD_W (20),
    .FIELD_H (20),
    .BLK_N   (4),
    .POS_W   (5)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_start            (start),
    .i_mode             (mode),
    .i_block_pos_x      (px),
    .i_block_pos_y      (py),
    .i_block_matrix     (mat),
    .i_field_background (bg),
    .o_busy             (o_busy),
    .o_done             (o_done),
    .o_collision        (o_collision),
    .o_hit_count        (o_hit_count),
    .o_field_display    (o_field_display)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  string          q_name[$];
  logic [NB-1:0]  q_field[$];
  logic           q_col[$];
  logic [HCW-1:0] q_hc[$];
  int unsigned    q_cyc[$];

  logic [NB-1:0] t_piece;
  logic [NB-1:0] one_bit;
  logic [NB-1:0] two_bits;
  logic [NB-1:0] edge_f;
  logic [NB-1:0] bottom_f;
  logic [NB-1:0] overlap_bg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic check_field(input string name, input logic [NB-1:0] act,
                             input logic [NB-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    string          nm;
    logic [NB-1:0]  ef;
    logic           ec;
    logic [HCW-1:0] eh;
    int unsigned    ecyc;
    if (rst_n && o_done) begin
      if (q_name.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: done at cycle %0d, required no done", cyc);
      end else begin
        nm   = q_name.pop_front();
        ef   = q_field.pop_front();
        ec   = q_col.pop_front();
        eh   = q_hc.pop_front();
        ecyc = q_cyc.pop_front();
        check_field({nm, "_field"}, o_field_display, ef);
        check({nm, "_collision"}, 32'(o_collision), 32'(ec));
        check({nm, "_hit_count"}, 32'(o_hit_count), 32'(eh));
        check({nm, "_done_cycle"}, cyc, ecyc);
        check({nm, "_busy_at_done"}, 32'(o_busy), 32'd0);
      end
    end
  end

  task automatic start_op(input string name, input logic [1:0] m, input logic [4:0] x,
                          input logic [4:0] y, input logic [15:0] mt, input logic [NB-1:0] b,
                          input logic [NB-1:0] ef, input logic ec, input logic [HCW-1:0] eh);
    @(negedge clk);
    mode  = m;
    px    = x;
    py    = y;
    mat   = mt;
    bg    = b;
    start = 1'b1;
    q_name.push_back(name);
    q_field.push_back(ef);
    q_col.push_back(ec);
    q_hc.push_back(eh);
    q_cyc.push_back(cyc + 17);
    @(posedge clk);
    #1 start = 1'b0;
    check({name, "_busy_after_start"}, 32'(o_busy), 32'd1);
    // Scramble inputs: only the latched copies may influence the result.
    mode = ~m;
    px   = ~x;
    py   = ~y;
    mat  = ~mt;
    bg   = ~b;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    repeat (40) begin
      if (!seen) begin
        @(negedge clk);
        if (o_done) seen = 1'b1;
      end
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: no done within 40 cycles, required done", name);
    end
  endtask

  task automatic pulse_ignored_start(input logic [1:0] m, input logic [15:0] mt);
    mode  = m;
    px    = 5'd0;
    py    = 5'd0;
    mat   = mt;
    bg    = '1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    t_piece = '0;
    t_piece[104] = 1'b1;
    t_piece[123] = 1'b1;
    t_piece[124] = 1'b1;
    t_piece[125] = 1'b1;
    one_bit = '0;
    one_bit[104] = 1'b1;
    two_bits = '0;
    two_bits[123] = 1'b1;
    two_bits[125] = 1'b1;
    edge_f = '0;
    edge_f[18] = 1'b1;
    edge_f[19] = 1'b1;
    bottom_f = '0;
    bottom_f[381] = 1'b1;
    overlap_bg = '0;
    overlap_bg[124] = 1'b1;

    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_done", 32'(o_done), 32'd0);
    check("reset_collision", 32'(o_collision), 32'd0);
    check("reset_hit_count", 32'(o_hit_count), 32'd0);
    check_field("reset_field", o_field_display, '0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy_after_reset", 32'(o_busy), 32'd0);

    start_op("merge_t", 2'd1, 5'd3, 5'd5, 16'h0072, '0, t_piece, 1'b0, 5'd0);
    wait_done("merge_t");
    start_op("right_oob", 2'd1, 5'd18, 5'd0, 16'h000F, '0, edge_f, 1'b1, 5'd2);
    wait_done("right_oob");
    start_op("overlap", 2'd1, 5'd3, 5'd5, 16'h0072, overlap_bg, t_piece, 1'b1, 5'd1);
    wait_done("overlap");
    start_op("clear_full", 2'd2, 5'd3, 5'd5, 16'h0072, t_piece, '0, 1'b0, 5'd0);
    wait_done("clear_full");
    start_op("clear_empty", 2'd2, 5'd3, 5'd5, 16'h0072, '0, '0, 1'b1, 5'd4);
    wait_done("clear_empty");
    start_op("check_mode0", 2'd0, 5'd3, 5'd5, 16'h0072, one_bit, one_bit, 1'b1, 5'd1);
    wait_done("check_mode0");
    start_op("check_mode3", 2'd3, 5'd3, 5'd5, 16'h0072, two_bits, two_bits, 1'b1, 5'd2);
    wait_done("check_mode3");
    start_op("bottom_oob", 2'd1, 5'd0, 5'd19, 16'h0072, '0, bottom_f, 1'b1, 5'd3);
    wait_done("bottom_oob");
    start_op("all_oob", 2'd1, 5'd31, 5'd31, 16'hFFFF, t_piece, t_piece, 1'b1, 5'd16);
    wait_done("all_oob");

    // Starts during SCAN and in the DONE cycle are ignored.
    start_op("proto", 2'd1, 5'd3, 5'd5, 16'h0072, '0, t_piece, 1'b0, 5'd0);
    @(negedge clk);
    pulse_ignored_start(2'd2, 16'hFFFF);
    repeat (4) @(negedge clk);
    pulse_ignored_start(2'd0, 16'h1234);
    wait_done("proto");
    pulse_ignored_start(2'd1, 16'hFFFF);
    check("start_in_done_ignored_busy", 32'(o_busy), 32'd0);
    repeat (20) @(negedge clk);
    check_field("result_hold_field", o_field_display, t_piece);
    check("result_hold_busy", 32'(o_busy), 32'd0);

    // Reset in the middle of a scan discards everything and issues no done.
    @(negedge clk);
    mode  = 2'd1;
    px    = 5'd3;
    py    = 5'd5;
    mat   = 16'h0072;
    bg    = '1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    check("midscan_busy_before_reset", 32'(o_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midscan_reset_busy", 32'(o_busy), 32'd0);
    check("midscan_reset_collision", 32'(o_collision), 32'd0);
    check("midscan_reset_hit_count", 32'(o_hit_count), 32'd0);
    check_field("midscan_reset_field", o_field_display, '0);
    @(negedge clk) rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check("after_reset_busy", 32'(o_busy), 32'd0);
    check("after_reset_done", 32'(o_done), 32'd0);

    start_op("fresh_after_reset", 2'd1, 5'd3, 5'd5, 16'h0072, overlap_bg, t_piece, 1'b1, 5'd1);
    wait_done("fresh_after_reset");
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(q_name.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
